// File: rtl/if_stage_nwide_pkg.sv
// Shared widths and the instruction-queue entry layout for the N-wide fetch stage.
// No logic here; consumed by if_stage_nwide and if_inst_queue.
// Entry = one 32-bit instruction tagged with its own 64-bit PC.
package if_stage_nwide_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 64;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
  } iq_entry_t;

endpackage

// File: rtl/if_inst_queue.sv
// Circular instruction queue: up to WIDTH entries in and WIDTH entries out per cycle.
// Latency: written entries appear at the head outputs the cycle after the write.
// Backpressure: caller must only enqueue when free space >= WIDTH; dequeue is clamped to count.
module if_inst_queue
  import if_stage_nwide_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int DEQ_W = $clog2(WIDTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    enq_en,
  input  logic [CNT_W-1:0]        enq_cnt,
  input  iq_entry_t [WIDTH-1:0]   enq_data,
  input  logic [DEQ_W-1:0]        deq_req,
  output iq_entry_t [WIDTH-1:0]   head_data,
  output logic [WIDTH-1:0]        head_valid,
  output logic [CNT_W-1:0]        count
);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] deq_ext;
  logic [CNT_W-1:0] deq_amt;
  logic [CNT_W-1:0] enq_amt;

  // Clamp the dequeue request to what is actually held so the count never underflows.
  always_comb begin
    deq_ext = CNT_W'(deq_req);
    deq_amt = (deq_ext > count_q) ? count_q : deq_ext;
    enq_amt = enq_en ? enq_cnt : '0;
  end

  // Pointer/count state; flush wins over any same-cycle enqueue or dequeue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_amt);
      tail_q  <= tail_q + PTR_W'(enq_amt);
      count_q <= count_q - deq_amt + enq_amt;
    end
  end

  // Storage has no reset: entries are only observable while covered by count_q.
  always_ff @(posedge clock) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (enq_en && !flush && (CNT_W'(k) < enq_cnt)) begin
        mem[tail_q + PTR_W'(k)] <= enq_data[k];
      end
    end
  end

  // Head window: slot i is valid iff more than i entries are held; invalid slots read as zero.
  always_comb begin
    head_data  = '0;
    head_valid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      head_valid[i] = (count_q > CNT_W'(i));
      if (head_valid[i]) begin
        head_data[i] = mem[head_q + PTR_W'(i)];
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_stage_nwide.sv
// N-wide instruction fetch: PC register, aligned Imem request, and a queue of fetched instructions.
// Latency: a fetched line is visible on the if_* outputs one cycle after the fetch fires.
// Backpressure: fetch stalls while the queue lacks FETCH_WIDTH free entries or mem_busy is high.
module if_stage_nwide
  import if_stage_nwide_pkg::*;
#(
  parameter  int          FETCH_WIDTH = 2,
  parameter  int          QUEUE_DEPTH = 8,
  parameter  logic [63:0] RESET_PC    = 64'h0,
  localparam int          DC_W        = $clog2(FETCH_WIDTH + 1),
  localparam int          CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [INST_WIDTH*FETCH_WIDTH-1:0] Imem2proc_data,
  input  logic                              Imem2proc_valid,
  input  logic                              mem_busy,
  input  logic                              redirect_valid,
  input  logic [PC_WIDTH-1:0]               redirect_pc,
  input  logic [DC_W-1:0]                   dispatch_count,
  output logic [PC_WIDTH-1:0]               proc2Imem_addr,
  output logic [INST_WIDTH*FETCH_WIDTH-1:0] if_inst_out,
  output logic [PC_WIDTH*FETCH_WIDTH-1:0]   if_pc_out,
  output logic [PC_WIDTH*FETCH_WIDTH-1:0]   if_npc_out,
  output logic [FETCH_WIDTH-1:0]            if_valid_out,
  output logic [CNT_W-1:0]                  if_count_out
);

  localparam logic [PC_WIDTH-1:0] LINE_MASK  = PC_WIDTH'(4 * FETCH_WIDTH - 1);
  localparam logic [PC_WIDTH-1:0] LINE_BYTES = PC_WIDTH'(4 * FETCH_WIDTH);

  logic [PC_WIDTH-1:0]          pc_q;
  logic [PC_WIDTH-1:0]          line_addr;
  logic [PC_WIDTH-1:0]          slot_sel;
  logic [CNT_W-1:0]             q_count;
  logic [CNT_W-1:0]             q_free;
  logic [CNT_W-1:0]             enq_cnt;
  logic                         fire;
  iq_entry_t [FETCH_WIDTH-1:0]  enq_data;
  iq_entry_t [FETCH_WIDTH-1:0]  head_data;
  logic [FETCH_WIDTH-1:0]       head_valid;

  // Line address and fetch decision; all branches fall through, so no prediction state exists.
  always_comb begin
    line_addr = pc_q & ~LINE_MASK;
    slot_sel  = (pc_q & LINE_MASK) >> 2;
    q_free    = CNT_W'(QUEUE_DEPTH) - q_count;
    fire      = !redirect_valid && !mem_busy && Imem2proc_valid &&
                (q_free >= CNT_W'(FETCH_WIDTH));
    enq_cnt   = CNT_W'(FETCH_WIDTH) - CNT_W'(slot_sel);
  end

  assign proc2Imem_addr = line_addr;

  // Compact slots slot_sel..FETCH_WIDTH-1 down to enqueue positions 0.., dropping slots below the PC.
  always_comb begin
    enq_data = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (PC_WIDTH'(j) == slot_sel + PC_WIDTH'(k)) begin
          enq_data[k].inst = Imem2proc_data[INST_WIDTH*j +: INST_WIDTH];
          enq_data[k].pc   = line_addr + PC_WIDTH'(4 * j);
        end
      end
    end
  end

  // PC register: redirect has priority, a fire advances to the next line, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (fire) begin
      pc_q <= line_addr + LINE_BYTES;
    end
  end

  if_inst_queue #(
    .WIDTH (FETCH_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .enq_en     (fire),
    .enq_cnt    (enq_cnt),
    .enq_data   (enq_data),
    .deq_req    (dispatch_count),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (q_count)
  );

  // Flatten the head window onto the slot buses; invalid slots drive zero on every field.
  always_comb begin
    if_inst_out = '0;
    if_pc_out   = '0;
    if_npc_out  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if_inst_out[INST_WIDTH*i +: INST_WIDTH] = head_data[i].inst;
      if_pc_out[PC_WIDTH*i +: PC_WIDTH]       = head_data[i].pc;
      if_npc_out[PC_WIDTH*i +: PC_WIDTH]      = head_valid[i] ? (head_data[i].pc + PC_WIDTH'(4)) : '0;
    end
  end

  assign if_valid_out = head_valid;
  assign if_count_out = q_count;

endmodule

// File: tb/tb_if_stage_nwide.sv
// Bench for if_stage_nwide at FETCH_WIDTH=2, QUEUE_DEPTH=8, RESET_PC=0.
// Expected queue contents live in a scoreboard queue: pushed when a fetch is driven, popped on dispatch.
// Every cycle the head window, count and fetch address are compared against that scoreboard.
module tb_if_stage_nwide;

  localparam int FW = 2;
  localparam int QD = 8;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_ent_t;

  logic          clock;
  logic          reset;
  logic [63:0]   Imem2proc_data;
  logic          Imem2proc_valid;
  logic          mem_busy;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic [1:0]    dispatch_count;
  logic [63:0]   proc2Imem_addr;
  logic [63:0]   if_inst_out;
  logic [127:0]  if_pc_out;
  logic [127:0]  if_npc_out;
  logic [1:0]    if_valid_out;
  logic [3:0]    if_count_out;

  exp_ent_t      sb[$];
  logic [63:0]   mpc;
  int            checks;
  int            failures;

  if_stage_nwide #(
    .FETCH_WIDTH (FW),
    .QUEUE_DEPTH (QD),
    .RESET_PC    (64'h0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .Imem2proc_data  (Imem2proc_data),
    .Imem2proc_valid (Imem2proc_valid),
    .mem_busy        (mem_busy),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dispatch_count  (dispatch_count),
    .proc2Imem_addr  (proc2Imem_addr),
    .if_inst_out     (if_inst_out),
    .if_pc_out       (if_pc_out),
    .if_npc_out      (if_npc_out),
    .if_valid_out    (if_valid_out),
    .if_count_out    (if_count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the scoreboard by one clock using the inputs currently driven.
  task automatic model_step();
    bit          fire;
    int          n;
    int          off;
    logic [63:0] base;
    exp_ent_t    e;
    if (reset) begin
      sb.delete();
      mpc = 64'h0;
    end else if (redirect_valid) begin
      sb.delete();
      mpc = redirect_pc;
    end else begin
      fire = !mem_busy && Imem2proc_valid && ((QD - sb.size()) >= FW);
      n = int'(dispatch_count);
      if (n > sb.size()) n = sb.size();
      repeat (n) void'(sb.pop_front());
      if (fire) begin
        base = {mpc[63:3], 3'b000};
        off  = int'(mpc[2:2]);
        for (int s = off; s < FW; s++) begin
          e.inst = Imem2proc_data[32*s +: 32];
          e.pc   = base + 64'(4 * s);
          sb.push_back(e);
        end
        mpc = base + 64'(4 * FW);
      end
    end
  endtask

  task automatic check_outputs();
    logic [1:0]  ev;
    logic [31:0] ei;
    logic [63:0] ep;
    logic [63:0] en;
    chk("count", 64'(if_count_out), 64'(sb.size()));
    chk("addr", proc2Imem_addr, {mpc[63:3], 3'b000});
    ev = '0;
    for (int i = 0; i < FW; i++) begin
      if (i < sb.size()) begin
        ev[i] = 1'b1;
        ei = sb[i].inst;
        ep = sb[i].pc;
        en = sb[i].pc + 64'd4;
      end else begin
        ei = '0;
        ep = '0;
        en = '0;
      end
      chk($sformatf("inst%0d", i), 64'(if_inst_out[32*i +: 32]), 64'(ei));
      chk($sformatf("pc%0d", i), if_pc_out[64*i +: 64], ep);
      chk($sformatf("npc%0d", i), if_npc_out[64*i +: 64], en);
    end
    chk("valid", 64'(if_valid_out), 64'(ev));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  initial begin
    int exp_cnt[6];
    int exp_adr[6];
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    Imem2proc_data  = 64'h0;
    Imem2proc_valid = 1'b0;
    mem_busy        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    dispatch_count  = 2'd0;
    mpc             = 64'h0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    chk("rst_count", 64'(if_count_out), 64'd0);
    chk("rst_addr", proc2Imem_addr, 64'h0);

    // First fetch right after reset release, steady dispatch of 2
    reset           = 1'b0;
    Imem2proc_data  = 64'h1111_1111_2222_2222;
    Imem2proc_valid = 1'b1;
    dispatch_count  = 2'd2;
    cycle();
    chk("first_inst0", 64'(if_inst_out[31:0]), 64'h2222_2222);
    chk("first_pc0", if_pc_out[63:0], 64'h0);
    chk("first_npc0", if_npc_out[63:0], 64'h4);
    chk("first_inst1", 64'(if_inst_out[63:32]), 64'h1111_1111);
    chk("first_pc1", if_pc_out[127:64], 64'h4);
    chk("first_valid", 64'(if_valid_out), 64'h3);
    chk("first_addr", proc2Imem_addr, 64'h8);
    cycle();
    chk("addr_16", proc2Imem_addr, 64'h10);
    cycle();
    chk("addr_24", proc2Imem_addr, 64'h18);

    // mem_busy: address holds, only dequeue moves the count
    mem_busy       = 1'b1;
    dispatch_count = 2'd0;
    cycle();
    chk("busy_addr", proc2Imem_addr, 64'h18);
    chk("busy_count", 64'(if_count_out), 64'd2);
    dispatch_count = 2'd1;
    cycle();
    chk("busy_deq_count", 64'(if_count_out), 64'd1);
    mem_busy = 1'b0;

    // Fill to full with no dispatch, then fetch stalls
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    dispatch_count = 2'd0;
    cycle();
    redirect_valid = 1'b0;
    exp_cnt = '{2, 4, 6, 8, 8, 8};
    exp_adr = '{8, 16, 24, 32, 32, 32};
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("fill_count%0d", k), 64'(if_count_out), 64'(exp_cnt[k]));
      chk($sformatf("fill_addr%0d", k), proc2Imem_addr, 64'(exp_adr[k]));
    end

    // Redirect beats a same-cycle dispatch and busy; refetch from a mid-line PC
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    cycle();
    redirect_valid = 1'b0;
    repeat (3) cycle();
    chk("pre_redir_count", 64'(if_count_out), 64'd6);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h14;
    dispatch_count = 2'd2;
    mem_busy       = 1'b1;
    cycle();
    chk("redir_count", 64'(if_count_out), 64'd0);
    chk("redir_valid", 64'(if_valid_out), 64'd0);
    chk("redir_addr", proc2Imem_addr, 64'h10);
    redirect_valid = 1'b0;
    mem_busy       = 1'b0;
    dispatch_count = 2'd0;
    cycle();
    chk("refetch_count", 64'(if_count_out), 64'd1);
    chk("refetch_pc0", if_pc_out[63:0], 64'h14);
    chk("refetch_inst0", 64'(if_inst_out[31:0]), 64'h1111_1111);
    chk("refetch_valid", 64'(if_valid_out), 64'h1);
    chk("refetch_addr", proc2Imem_addr, 64'h18);

    // Over-dispatch never underflows
    Imem2proc_valid = 1'b0;
    dispatch_count  = 2'd2;
    cycle();
    chk("underflow_count", 64'(if_count_out), 64'd0);
    cycle();
    chk("underflow_count2", 64'(if_count_out), 64'd0);

    // Build count=5, then reset mid-fetch takes effect before the next edge
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h4;
    dispatch_count  = 2'd0;
    cycle();
    redirect_valid  = 1'b0;
    Imem2proc_valid = 1'b1;
    repeat (3) cycle();
    chk("pre_reset_count", 64'(if_count_out), 64'd5);
    reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(if_count_out), 64'd0);
    chk("async_rst_addr", proc2Imem_addr, 64'h0);
    chk("async_rst_valid", 64'(if_valid_out), 64'd0);
    sb.delete();
    mpc = 64'h0;
    check_outputs();
    #3;
    cycle();
    reset = 1'b0;

    // Random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      Imem2proc_data  = {$urandom, $urandom};
      Imem2proc_valid = ($urandom_range(0, 3) != 0);
      mem_busy        = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_pc     = 64'($urandom_range(0, 255)) << 2;
      dispatch_count  = 2'($urandom_range(0, 2));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage_nwide.md
IF_STAGE_NWIDE -- requirements
Module: if_stage_nwide

Interface
REQ-001 Parameter FETCH_WIDTH, default 2: instructions per Imem word; power of 2, >=1.
REQ-002 Parameter QUEUE_DEPTH, default 8: instruction-queue entries; power of 2, >= 2*FETCH_WIDTH.
REQ-003 Parameter RESET_PC, default 64'h0: fetch PC after reset.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 Imem2proc_data  input  32*FETCH_WIDTH  fetched word; slot i = bits [32i+31:32i], lowest slot = lowest address.
REQ-007 Imem2proc_valid  input  1  Imem2proc_data valid this cycle.
REQ-008 mem_busy  input  1  data-side memory owns the bus; no fetch this cycle.
REQ-009 redirect_valid  input  1  mispredict or resolved taken branch; flush and refetch.
REQ-010 redirect_pc  input  64  new fetch PC; any 4-byte-aligned value.
REQ-011 dispatch_count  input  clog2(FETCH_WIDTH+1)  instructions consumed downstream this cycle.
REQ-012 proc2Imem_addr  output  64  fetch address, word-aligned.
REQ-013 if_inst_out  output  32*FETCH_WIDTH  queue head instructions, slot 0 = oldest.
REQ-014 if_pc_out / if_npc_out  output  64*FETCH_WIDTH each  PC and PC+4 per slot.
REQ-015 if_valid_out  output  FETCH_WIDTH  slot i valid iff queue count > i.
REQ-016 if_count_out  output  clog2(QUEUE_DEPTH+1)  current queue occupancy.

Function
REQ-017 proc2Imem_addr SHALL equal PC with the low log2(4*FETCH_WIDTH) bits cleared, combinationally.
REQ-018 Fetch fires in a cycle iff !redirect_valid && !mem_busy && Imem2proc_valid && (QUEUE_DEPTH - count) >= FETCH_WIDTH, count taken at cycle start.
REQ-019 On fire, slots from offset = PC[log2(4*FETCH_WIDTH)-1:2] to FETCH_WIDTH-1 SHALL be enqueued in address order, each with its own PC; lower slots dropped.
REQ-020 On fire, PC SHALL become proc2Imem_addr + 4*FETCH_WIDTH; otherwise PC holds (absent redirect).
REQ-021 Enqueued instructions SHALL be visible on outputs the cycle after fire (1-cycle latency).
REQ-022 Dequeue amount SHALL be min(dispatch_count, count); excess dispatch_count is ignored, never underflows.
REQ-023 Enqueue and dequeue in the same cycle SHALL both take effect; new count = count - deq + enq.
REQ-024 Head/tail pointers SHALL wrap modulo QUEUE_DEPTH; count never exceeds QUEUE_DEPTH.
REQ-025 redirect_valid SHALL have highest priority: next cycle count = 0, pointers reset, PC = redirect_pc; same-cycle fetch and dispatch discarded.
REQ-026 Invalid slots SHALL drive instruction and PC fields to zero.
REQ-027 All branches are predicted not-taken; no prediction state is kept.

Reset
REQ-028 While reset is high: PC = RESET_PC, count = 0, pointers = 0, if_valid_out = 0, data outputs 0; takes effect immediately, including mid-fetch.
REQ-029 First fetch SHALL occur in the first cycle after reset deasserts with fetch conditions met.

Structure
REQ-030 Shared package SHALL hold INST_WIDTH = 32, PC_WIDTH = 64, and the queue-entry typedef {inst, pc}.
REQ-031 The circular buffer SHALL be sub-module if_inst_queue (multi-enqueue/multi-dequeue, count output); PC/fetch control stays in the top.

Verification (FETCH_WIDTH=2, QUEUE_DEPTH=8, RESET_PC=0)
REQ-032 Reset, data 64'h1111_1111_2222_2222 valid, dispatch_count=2 -> addr 0,8,16...; one cycle after first fetch: inst0=32'h2222_2222 pc 0 npc 4, inst1=32'h1111_1111 pc 4, valid=2'b11.
REQ-033 mem_busy=1 for one cycle -> proc2Imem_addr holds, no enqueue, count unchanged except dequeue.
REQ-034 dispatch_count=0 for 6 cycles -> count 2,4,6,8 then fetch stalls, addr frozen at 0x20, count=8 held.
REQ-035 Queue holding 6, redirect to 0x14 with dispatch_count=2 and mem_busy=1 same cycle -> next cycle count 0, valid 0, addr 0x10; next fetch enqueues only pc 0x14, count=1, then addr 0x18.
REQ-036 count=1, dispatch_count=2 -> count 0, no underflow; reset asserted mid-run with count=5 -> count 0 and PC=0 before next posedge.
